// File: rtl/sram_block_master.sv
// sram_block_master
//   Initiator-side burst controller for the byte-wide SRAM wrapper behind the
//   Triple-DES datapath. A write request sends one 64-bit block as an 8-byte
//   burst, MSB first. A read request fetches 8 bytes and reassembles them into
//   a 64-bit block.
//
//   Optional feature macro: SRAM_BLOCK_CKSUM_EN (adds a read checksum and a
//   checksum-mismatch pulse).
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   wr_req         write request pulse (sampled only while idle)
//   wr_block[63:0] block to write, sampled on the accepting edge
//   rd_req         read request pulse (sampled only while idle)
//   busy           high from burst start through the last gap cycle
//   wr_done        one-cycle pulse, write burst finished
//   rd_valid       one-cycle pulse, rd_block updated
//   rd_block[63:0] last assembled read block
//   enable         burst start strobe to the SRAM wrapper
//   rw_mode        0 = write, 1 = read, held for the burst
//   write_data[7:0] write byte to the SRAM wrapper
//   read_data[7:0]  read byte from the SRAM wrapper
//   expected_cksum[7:0], rd_cksum[7:0], cksum_err  (SRAM_BLOCK_CKSUM_EN only)
module sram_block_master #(
    parameter int RD_LATENCY = 1,
    parameter int IDLE_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [63:0] wr_block,
    input  logic        rd_req,
    output logic        busy,
    output logic        wr_done,
    output logic        rd_valid,
    output logic [63:0] rd_block,
    output logic        enable,
    output logic        rw_mode,
    output logic [7:0]  write_data,
`ifdef SRAM_BLOCK_CKSUM_EN
    input  logic [7:0]  expected_cksum,
    output logic [7:0]  rd_cksum,
    output logic        cksum_err,
`endif
    input  logic [7:0]  read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SETUP,
        S_XFER,
        S_DONE,
        S_GAP
    } state_t;

    // Wait cycles between SETUP and the first read sample.
    localparam logic [1:0] RD_WAIT  = 2'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LAST = (IDLE_GAP == 0) ? 4'd0 : 4'(IDLE_GAP - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_is_read;
    logic        r_pend;
    logic [2:0]  r_byte_cnt;
    logic [1:0]  r_wait;
    logic [3:0]  r_gap;
    logic [63:0] r_wr_shift;
    logic [55:0] r_rd_shift;
    logic [63:0] r_rd_block;
    logic        w_step;
    logic        w_xfer_end;
    logic [63:0] w_rd_full;

    function automatic logic [7:0] f_xor_bytes(input logic [63:0] blk);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ blk[8*i +: 8];
        end
        return acc;
    endfunction

    // A byte moves this cycle: every write XFER cycle, or a read XFER cycle
    // once the latency wait has run out.
    assign w_step     = (r_state == S_XFER) && (!r_is_read || (r_wait == 2'd0));
    assign w_xfer_end = w_step && (r_byte_cnt == 3'd7);
    assign w_rd_full  = {r_rd_shift, read_data};

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---- next state and outputs ----
    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        enable     = 1'b0;
        rw_mode    = 1'b0;
        write_data = 8'h00;
        wr_done    = 1'b0;
        rd_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (wr_req || rd_req) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                enable  = 1'b1;
                rw_mode = r_is_read;
                w_next  = S_SETUP;
            end
            S_SETUP: begin
                rw_mode = r_is_read;
                w_next  = S_XFER;
            end
            S_XFER: begin
                rw_mode = r_is_read;
                if (!r_is_read) begin
                    write_data = r_wr_shift[63:56];
                end
                if (w_xfer_end) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                wr_done  = !r_is_read;
                rd_valid = r_is_read;
                if (IDLE_GAP != 0) begin
                    w_next = S_GAP;
                end else if (r_pend) begin
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap == 4'd0) begin
                    w_next = r_pend ? S_START : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---- burst control: operation type, pending read, counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_read  <= 1'b0;
            r_pend     <= 1'b0;
            r_byte_cnt <= 3'd0;
            r_wait     <= 2'd0;
            r_gap      <= 4'd0;
            r_rd_block <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Write wins a tie; the read waits in r_pend.
                    if (wr_req) begin
                        r_is_read <= 1'b0;
                        r_pend    <= rd_req;
                    end else if (rd_req) begin
                        r_is_read <= 1'b1;
                        r_pend    <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_wait     <= RD_WAIT;
                    r_byte_cnt <= 3'd0;
                end
                S_XFER: begin
                    if (w_step) begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                S_DONE: begin
                    r_gap <= GAP_LAST;
                    if ((IDLE_GAP == 0) && r_pend) begin
                        r_is_read <= 1'b1;
                        r_pend    <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - 4'd1;
                    if ((r_gap == 4'd0) && r_pend) begin
                        r_is_read <= 1'b1;
                        r_pend    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
            // Loaded on the edge into DONE so it is visible with rd_valid.
            if (w_xfer_end && r_is_read) begin
                r_rd_block <= w_rd_full;
            end
        end
    end

    // ---- data shift registers ----
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && wr_req) begin
            r_wr_shift <= wr_block;
        end else if ((r_state == S_XFER) && !r_is_read) begin
            r_wr_shift <= {r_wr_shift[55:0], 8'h00};
        end
        if (w_step && r_is_read) begin
            r_rd_shift <= {r_rd_shift[47:0], read_data};
        end
    end

    assign rd_block = r_rd_block;

`ifdef SRAM_BLOCK_CKSUM_EN
    logic [7:0] r_rd_cksum;
    logic [7:0] r_exp_cksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cksum  <= 8'h00;
            r_exp_cksum <= 8'h00;
        end else begin
            if ((r_state == S_IDLE) && rd_req) begin
                r_exp_cksum <= expected_cksum;
            end
            if (w_xfer_end && r_is_read) begin
                r_rd_cksum <= f_xor_bytes(w_rd_full);
            end
        end
    end

    assign rd_cksum  = r_rd_cksum;
    assign cksum_err = rd_valid && (r_rd_cksum != r_exp_cksum);
`endif

endmodule

// File: tb/tb_sram_block_master.sv
// Bench for sram_block_master: directed and randomized bursts checked cycle
// by cycle against a timeline model built from the burst rules.
module tb_sram_block_master;

    localparam int L = 1;
    localparam int G = 2;
    localparam int NMAX = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [63:0] wr_block;
    logic        rd_req;
    logic        busy;
    logic        wr_done;
    logic        rd_valid;
    logic [63:0] rd_block;
    logic        enable;
    logic        rw_mode;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic [7:0]  exp_ck_in;
`ifdef SRAM_BLOCK_CKSUM_EN
    logic [7:0]  rd_cksum;
    logic        cksum_err;
`endif

    int checks = 0;
    int failures = 0;

    // Expected timeline, indexed by cycle number after the accepting edge.
    logic        e_en   [NMAX];
    logic        e_rw   [NMAX];
    logic        e_busy [NMAX];
    logic        e_wrd  [NMAX];
    logic        e_rv   [NMAX];
    logic        e_err  [NMAX];
    logic [7:0]  e_wd   [NMAX];
    logic [7:0]  e_ck   [NMAX];
    logic [7:0]  drv    [NMAX];
    logic [63:0] new_blk[NMAX];
    logic [63:0] e_blk  [NMAX];
    logic [63:0] model_blk = 64'd0;
    logic [7:0]  model_ck  = 8'h00;

    sram_block_master #(.RD_LATENCY(L), .IDLE_GAP(G)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_block(wr_block), .rd_req(rd_req),
        .busy(busy), .wr_done(wr_done), .rd_valid(rd_valid), .rd_block(rd_block),
        .enable(enable), .rw_mode(rw_mode), .write_data(write_data),
`ifdef SRAM_BLOCK_CKSUM_EN
        .expected_cksum(exp_ck_in), .rd_cksum(rd_cksum), .cksum_err(cksum_err),
`endif
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [7:0] xor8(input logic [63:0] b);
        logic [7:0] a;
        a = 8'h00;
        for (int i = 0; i < 8; i++) a = a ^ b[8*i +: 8];
        return a;
    endfunction

    task automatic clear_exp();
        for (int c = 0; c < NMAX; c++) begin
            e_en[c] = 0; e_rw[c] = 0; e_busy[c] = 0; e_wrd[c] = 0; e_rv[c] = 0;
            e_err[c] = 0; e_wd[c] = 8'h00; e_ck[c] = 8'h00; new_blk[c] = 64'd0;
            drv[c] = 8'($urandom_range(0, 255));
        end
    endtask

    // Write burst: strobe at 1, bytes MSB-first at 3..10, done at 11, gap after.
    task automatic add_write(input int b, input logic [63:0] blk, input int kill);
        for (int k = 1; k <= 11 + G; k++) begin
            int c;
            c = b + k;
            if (c < kill) begin
                e_busy[c] = 1;
                e_en[c]   = (k == 1);
                e_wrd[c]  = (k == 11);
                if (k >= 3 && k <= 10) e_wd[c] = blk[63 - 8*(k-3) -: 8];
            end
        end
    endtask

    // Read burst: bytes presented in cycles 2+L..9+L, valid at 10+L.
    task automatic add_read(input int b, input logic [63:0] bytes, input logic [7:0] eck, input int kill);
        for (int k = 1; k <= 10 + L + G; k++) begin
            int c;
            c = b + k;
            if (k >= 2 + L && k <= 9 + L) drv[c] = bytes[63 - 8*(k-2-L) -: 8];
            if (c < kill) begin
                e_busy[c] = 1;
                e_en[c]   = (k == 1);
                e_rw[c]   = (k <= 9 + L);
                if (k == 10 + L) begin
                    e_rv[c]    = 1;
                    new_blk[c] = bytes;
                    e_ck[c]    = xor8(bytes);
                    e_err[c]   = (xor8(bytes) != eck);
                end
            end
        end
    endtask

    task automatic finalize(input int n, input int kill);
        for (int c = 1; c <= n; c++) begin
            if (c >= kill) begin
                model_blk = 64'd0;
                model_ck  = 8'h00;
            end else if (e_rv[c]) begin
                model_blk = new_blk[c];
                model_ck  = e_ck[c];
            end
            e_blk[c] = model_blk;
            e_ck[c]  = model_ck;
        end
    endtask

    // Caller sets the request pulses at a negedge; this consumes edge 0 and
    // then checks cycles 1..n at each following negedge.
    task automatic run(input int n, input int inj_c, input int rst_c);
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            wr_req = 0;
            rd_req = 0;
            chk("enable", c, 64'(enable), 64'(e_en[c]));
            chk("rw_mode", c, 64'(rw_mode), 64'(e_rw[c]));
            chk("busy", c, 64'(busy), 64'(e_busy[c]));
            chk("write_data", c, 64'(write_data), 64'(e_wd[c]));
            chk("wr_done", c, 64'(wr_done), 64'(e_wrd[c]));
            chk("rd_valid", c, 64'(rd_valid), 64'(e_rv[c]));
            chk("rd_block", c, rd_block, e_blk[c]);
`ifdef SRAM_BLOCK_CKSUM_EN
            chk("rd_cksum", c, 64'(rd_cksum), 64'(e_ck[c]));
            chk("cksum_err", c, 64'(cksum_err), 64'(e_err[c] && e_rv[c]));
`endif
            wr_req    = (c == inj_c);
            rst       = (c == rst_c);
            read_data = drv[c];
        end
        wr_req = 0;
        rst    = 0;
    endtask

    task automatic req(input logic w, input logic r, input logic [63:0] blk, input logic [7:0] eck);
        wr_req    = w;
        rd_req    = r;
        wr_block  = blk;
        exp_ck_in = eck;
    endtask

    initial begin
        logic [63:0] blk;
        logic [63:0] bytes;
        logic [7:0]  eck;
        int op;
        int n;

        rst = 1; wr_req = 0; rd_req = 0; wr_block = 64'd0; read_data = 8'h00; exp_ck_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 0, 64'(busy), 64'd0);
        chk("rst_enable", 0, 64'(enable), 64'd0);
        chk("rst_rw_mode", 0, 64'(rw_mode), 64'd0);
        chk("rst_write_data", 0, 64'(write_data), 64'd0);
        chk("rst_wr_done", 0, 64'(wr_done), 64'd0);
        chk("rst_rd_valid", 0, 64'(rd_valid), 64'd0);
        chk("rst_rd_block", 0, rd_block, 64'd0);
        rst = 0;
        @(negedge clk);

        // Directed write.
        blk = 64'h901AEDF181F868B4;
        clear_exp(); add_write(0, blk, 1000); finalize(16, 1000);
        req(1, 0, blk, 8'h00);
        run(16, 0, 0);

        // Directed read, checksum matches.
        bytes = 64'h123456789ABCEDF0;
        clear_exp(); add_read(0, bytes, 8'h33, 1000); finalize(15, 1000);
        req(0, 1, 64'd0, 8'h33);
        run(15, 0, 0);

        // Same read, checksum mismatch.
        clear_exp(); add_read(0, bytes, 8'h34, 1000); finalize(15, 1000);
        req(0, 1, 64'd0, 8'h34);
        run(15, 0, 0);

        // Simultaneous requests: write first, read follows with no idle cycle.
        blk = {$urandom, $urandom};
        bytes = {$urandom, $urandom};
        clear_exp(); add_write(0, blk, 1000); add_read(11 + G, bytes, 8'h5A, 1000);
        n = 11 + G + 10 + L + G + 2;
        finalize(n, 1000);
        req(1, 1, blk, 8'h5A);
        run(n, 0, 0);

        // Write request during a write burst is ignored.
        blk = {$urandom, $urandom};
        clear_exp(); add_write(0, blk, 1000); finalize(18, 1000);
        req(1, 0, blk, 8'h00);
        run(18, 5, 0);

        // Reset in cycle 6 of a read, then a normal read.
        bytes = {$urandom, $urandom};
        clear_exp(); add_read(0, bytes, 8'h00, 7); finalize(10, 7);
        req(0, 1, 64'd0, 8'h00);
        run(10, 0, 6);
        bytes = {$urandom, $urandom};
        clear_exp(); add_read(0, bytes, xor8(bytes), 1000); finalize(15, 1000);
        req(0, 1, 64'd0, xor8(bytes));
        run(15, 0, 0);

        // Randomized bursts.
        for (int i = 0; i < 10; i++) begin
            op    = int'($urandom_range(0, 2));
            blk   = {$urandom, $urandom};
            bytes = {$urandom, $urandom};
            eck   = (i % 2 == 0) ? xor8(bytes) : 8'($urandom_range(0, 255));
            clear_exp();
            if (op == 0) begin
                add_write(0, blk, 1000);
                n = 11 + G + 2;
            end else if (op == 1) begin
                add_read(0, bytes, eck, 1000);
                n = 10 + L + G + 2;
            end else begin
                add_write(0, blk, 1000);
                add_read(11 + G, bytes, eck, 1000);
                n = 11 + G + 10 + L + G + 2;
            end
            finalize(n, 1000);
            req(op != 1, op != 0, blk, eck);
            run(n, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
